// File: rtl/dazzler_spi_tx.sv
// dazzler_spi_tx: serialises one 64x64 RGBI frame onto the dazzler SPI link.
// Reads a 4-bit-per-pixel framebuffer through a synchronous read port and sends
// it in quadrant order (TL, TR, BL, BR), each pixel LSB first (I, B, G, R).
// Ports:
//   CLK25MHz  system clock
//   rst_n     asynchronous active-low reset
//   start     single-cycle frame request, honoured only while idle
//   busy      high from accepted start until done
//   done      one-cycle pulse after the trailing gap
//   pix_addr  framebuffer address {row[5:0], col[5:0]}
//   pix_data  framebuffer data {R,G,B,I}, valid one clock after pix_addr changes
//   sclk      serial clock, idle low
//   vsync     frame sync, low only during the sync burst
//   cs        chip select, active low during pixel data
//   mosi      serial data, launched at the start of each sclk low phase
// Build option: define DAZZLER_TX_AUTO_EN to send frames back to back forever,
// the first one GAP_CLKS cycles after reset; start is then ignored.
module dazzler_spi_tx #(
    parameter int SCLK_DIV  = 2,
    parameter int SYNC_CLKS = 2,
    parameter int GAP_CLKS  = 16
) (
    input  logic        CLK25MHz,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [11:0] pix_addr,
    input  logic [3:0]  pix_data,
    output logic        sclk,
    output logic        vsync,
    output logic        cs,
    output logic        mosi
);
    localparam int DW = $clog2(SCLK_DIV + 1);
    localparam int GW = $clog2(GAP_CLKS + 1);
    localparam int SW = $clog2(SYNC_CLKS + 1);

    typedef enum logic [2:0] {IDLE, SYNC, GAP1, SHIFT, GAP2} state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   div_q, div_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [SW-1:0]   syn_q, syn_d;
    logic [1:0]      bit_q, bit_d;
    logic [11:0]     pix_q, pix_d;
    logic [3:0]      sreg_q, sreg_d;
    logic [3:0]      nxt_q, nxt_d;
    logic [1:0]      pf_q, pf_d;
    logic [11:0]     addr_q, addr_d;
    logic            sclk_q, sclk_d;
    logic            vsync_q, vsync_d;
    logic            cs_q, cs_d;
    logic            mosi_q, mosi_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            tick;
    logic            go;

    // Wire index n -> framebuffer address: n[11] picks the bottom half, n[10]
    // the right half, n[9:5] and n[4:0] are row/col inside the quadrant.
    function automatic logic [11:0] pix_map(input logic [11:0] n);
        return {n[11], n[9:5], n[10], n[4:0]};
    endfunction

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        gap_d   = gap_q;
        syn_d   = syn_q;
        bit_d   = bit_q;
        pix_d   = pix_q;
        sreg_d  = sreg_q;
        nxt_d   = nxt_q;
        pf_d    = {pf_q[0], 1'b0};
        addr_d  = addr_q;
        sclk_d  = sclk_q;
        vsync_d = vsync_q;
        cs_d    = cs_q;
        mosi_d  = mosi_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        go      = 1'b0;
        tick    = div_q == DW'(SCLK_DIV - 1);
        // pf_q[1] marks the cycle in which the prefetched pixel is valid
        if (pf_q[1]) nxt_d = pix_data;
        case (state_q)
            IDLE: begin
`ifdef DAZZLER_TX_AUTO_EN
                gap_d = gap_q + 1'b1;
                go    = gap_q == GW'(GAP_CLKS - 1);
`else
                go    = start;
`endif
            end
            SYNC: begin
                div_d = tick ? '0 : div_q + 1'b1;
                if (tick) begin
                    sclk_d = ~sclk_q;
                    if (sclk_q && syn_q == SW'(SYNC_CLKS - 1)) begin
                        state_d = GAP1;
                        vsync_d = 1'b1;
                        gap_d   = '0;
                        addr_d  = '0;
                    end else if (sclk_q) begin
                        syn_d = syn_q + 1'b1;
                    end
                end
            end
            GAP1: begin
                gap_d = gap_q + 1'b1;
                if (gap_q == GW'(GAP_CLKS - 1)) begin
                    state_d = SHIFT;
                    cs_d    = 1'b0;
                    sreg_d  = pix_data;
                    mosi_d  = pix_data[0];
                    bit_d   = '0;
                    pix_d   = '0;
                    div_d   = '0;
                    addr_d  = pix_map(12'd1);
                    pf_d[0] = 1'b1;
                end
            end
            SHIFT: begin
                div_d = tick ? '0 : div_q + 1'b1;
                if (tick) begin
                    sclk_d = ~sclk_q;
                    // falling sclk: the current bit has been sampled
                    if (sclk_q && bit_q == 2'd3 && pix_q == 12'd4095) begin
                        state_d = GAP2;
                        cs_d    = 1'b1;
                        mosi_d  = 1'b0;
                        gap_d   = '0;
                    end else if (sclk_q && bit_q == 2'd3) begin
                        pix_d   = pix_q + 12'd1;
                        bit_d   = '0;
                        sreg_d  = nxt_q;
                        mosi_d  = nxt_q[0];
                        addr_d  = pix_q == 12'd4094 ? addr_q : pix_map(pix_q + 12'd2);
                        pf_d[0] = 1'b1;
                    end else if (sclk_q) begin
                        bit_d  = bit_q + 2'd1;
                        sreg_d = {1'b0, sreg_q[3:1]};
                        mosi_d = sreg_q[1];
                    end
                end
            end
            GAP2: begin
                gap_d = gap_q + 1'b1;
                if (gap_q == GW'(GAP_CLKS - 1)) begin
                    done_d = 1'b1;
`ifdef DAZZLER_TX_AUTO_EN
                    go = 1'b1;
`else
                    state_d = IDLE;
                    busy_d  = 1'b0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
        if (go) begin
            state_d = SYNC;
            busy_d  = 1'b1;
            vsync_d = 1'b0;
            cs_d    = 1'b1;
            sclk_d  = 1'b0;
            div_d   = '0;
            syn_d   = '0;
        end
    end

    always_ff @(posedge CLK25MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            div_q   <= '0;
            gap_q   <= '0;
            syn_q   <= '0;
            bit_q   <= '0;
            pix_q   <= '0;
            sreg_q  <= '0;
            nxt_q   <= '0;
            pf_q    <= '0;
            addr_q  <= '0;
            sclk_q  <= 1'b0;
            vsync_q <= 1'b1;
            cs_q    <= 1'b1;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            gap_q   <= gap_d;
            syn_q   <= syn_d;
            bit_q   <= bit_d;
            pix_q   <= pix_d;
            sreg_q  <= sreg_d;
            nxt_q   <= nxt_d;
            pf_q    <= pf_d;
            addr_q  <= addr_d;
            sclk_q  <= sclk_d;
            vsync_q <= vsync_d;
            cs_q    <= cs_d;
            mosi_q  <= mosi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign sclk     = sclk_q;
    assign vsync    = vsync_q;
    assign cs       = cs_q;
    assign mosi     = mosi_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign pix_addr = addr_q;
endmodule

// File: tb/tb_dazzler_spi_tx.sv
// tb_dazzler_spi_tx: self-checking bench for dazzler_spi_tx with a wire-level receiver model.
`timescale 1ns/1ps
module tb_dazzler_spi_tx;
    localparam int SD = 2, SC = 2, GC = 16;
    localparam int FLEN = 2*SD*(SC+16384) + 2*GC + 2;

    typedef struct {int n; int row; int col;} vec_t;

    logic        clk = 0, rst_n = 0, start = 0;
    logic        busy, done, sclk, vsync, cs, mosi;
    logic [11:0] pix_addr;
    logic [3:0]  pix_data;
    logic [3:0]  mem [4096];
    bit          rx_q [$];
    int          total = 0, bad = 0, cyc_cnt = 0;
    int          sync_e = 0, stray_e = 0, done_n = 0, unstable = 0, idle_mosi = 0, busy_lo = 0;
    bit          watch_busy = 0, prev_ok = 0;
    logic [2:0]  prev;
    vec_t        tbl [10];

    dazzler_spi_tx #(.SCLK_DIV(SD), .SYNC_CLKS(SC), .GAP_CLKS(GC)) dut (
        .CLK25MHz(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .pix_addr(pix_addr), .pix_data(pix_data), .sclk(sclk), .vsync(vsync),
        .cs(cs), .mosi(mosi));

    always #5 clk = ~clk;
    always @(posedge clk) pix_data <= mem[pix_addr];
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // receiver: samples on sclk rising
    always @(posedge sclk) begin
        if (!cs) rx_q.push_back(mosi);
        else if (!vsync) sync_e++;
        else stray_e++;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (done) done_n++;
            if (cs && mosi) idle_mosi++;
            if (watch_busy && !busy) busy_lo++;
            if (sclk && prev_ok && {mosi, cs, vsync} != prev) unstable++;
            prev = {mosi, cs, vsync};
            prev_ok = 1;
        end else prev_ok = 0;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int addr_of(input int n);
        int row, col;
        row = (n / 2048) * 32 + (n % 1024) / 32;
        col = ((n / 1024) % 2) * 32 + n % 32;
        return row * 64 + col;
    endfunction

    function automatic logic [3:0] rx_nib(input int n);
        if (rx_q.size() < 4*n + 4) return 4'hx;
        return {rx_q[4*n+3], rx_q[4*n+2], rx_q[4*n+1], rx_q[4*n]};
    endfunction

    task automatic clear_rx();
        rx_q.delete();
        sync_e = 0;
        stray_e = 0;
        done_n = 0;
    endtask

    task automatic pulse_start(output int t);
        @(negedge clk);
        start = 1;
        @(posedge clk);
        #1;
        start = 0;
        t = cyc_cnt;
    endtask

    task automatic wait_done(input int lim, output bit ok);
        int k = 0;
        while (!done && k < lim) begin
            @(posedge clk);
            #1;
            k++;
        end
        ok = done;
    endtask

    task automatic wait_bits(input int nb, input int lim, output bit ok);
        int k = 0;
        while (rx_q.size() < nb && k < lim) begin
            @(posedge clk);
            #1;
            k++;
        end
        ok = rx_q.size() >= nb;
    endtask

    function automatic int frame_mism(input int npix);
        int m = 0;
        for (int n = 0; n < npix; n++) if (rx_nib(n) !== mem[addr_of(n)]) m++;
        return m;
    endfunction

    initial begin
        bit ok;
        int t0, t1;
        tbl[0] = '{0, 0, 0};     tbl[1] = '{1, 0, 1};     tbl[2] = '{31, 0, 31};
        tbl[3] = '{32, 1, 0};    tbl[4] = '{1023, 31, 31}; tbl[5] = '{1024, 0, 32};
        tbl[6] = '{1055, 0, 63}; tbl[7] = '{2048, 32, 0}; tbl[8] = '{3072, 32, 32};
        tbl[9] = '{4095, 63, 63};
        for (int a = 0; a < 4096; a++) mem[a] = 4'(a);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sclk", sclk, 0);
        chk("rst_vsync", vsync, 1);
        chk("rst_cs", cs, 1);
        chk("rst_mosi", mosi, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_addr", pix_addr, 0);
        @(negedge clk);
        rst_n = 1;
`ifdef DAZZLER_TX_AUTO_EN
        clear_rx();
        start = 0;
        repeat (GC + 2) @(posedge clk);
        #1;
        chk("auto_busy_up", busy, 1);
        watch_busy = 1;
        for (int f = 0; f < 2; f++) begin
            wait_done(70000, ok);
            chk("auto_done_timeout", ok, 1);
            chk("auto_sync_edges", sync_e, SC);
            chk("auto_data_edges", rx_q.size(), 16384);
            chk("auto_pixels", frame_mism(4096), 0);
            chk("auto_busy_at_done", busy, 1);
            rx_q.delete();
            sync_e = 0;
            @(posedge clk);
            #1;
        end
        chk("auto_busy_lo", busy_lo, 0);
`else
        // frame A: ramp, interrupted by reset mid-shift
        clear_rx();
        pulse_start(t0);
        chk("ack_busy", busy, 1);
        chk("ack_vsync", vsync, 0);
        wait_bits(4200, 20000, ok);
        chk("a_bits_timeout", ok, 1);
        chk("a_sync_edges", sync_e, SC);
        chk("a_stray", stray_e, 0);
        chk("a_first_pix", rx_nib(0), 0);
        chk("a_pix1024", rx_nib(1024), mem[12'h020]);
        chk("a_ramp_pixels", frame_mism(1050), 0);
        #3 rst_n = 0;
        #1;
        chk("mid_rst_sclk", sclk, 0);
        chk("mid_rst_cs", cs, 1);
        chk("mid_rst_vsync", vsync, 1);
        chk("mid_rst_mosi", mosi, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_addr", pix_addr, 0);
        @(negedge clk);
        rst_n = 1;
        // frame B: random image plus marker, stray start during shift
        for (int a = 0; a < 4096; a++) mem[a] = 4'($urandom_range(0, 15));
        mem[{6'd32, 6'd0}] = 4'hF;
        clear_rx();
        pulse_start(t0);
        chk("b_ack_busy", busy, 1);
        wait_bits(2000, 10000, ok);
        chk("b_bits_timeout", ok, 1);
        @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
        wait_done(70000, ok);
        t1 = cyc_cnt;
        chk("b_done_timeout", ok, 1);
        chk("b_frame_len", t1 - t0 + 2, FLEN);
        chk("b_busy_at_done", busy, 0);
        chk("b_cs_at_done", cs, 1);
        // restart in the done cycle
        start = 1;
        @(posedge clk);
        #1;
        start = 0;
        chk("c_busy", busy, 1);
        chk("c_vsync", vsync, 0);
        chk("b_done_pulses", done_n, 1);
        chk("b_sync_edges", sync_e, SC);
        chk("b_data_edges", rx_q.size(), 16384);
        chk("b_stray", stray_e, 0);
        chk("b_pixels", frame_mism(4096), 0);
        chk("b_marker", rx_nib(2048), 4'hF);
        for (int i = 0; i < 10; i++)
            chk($sformatf("tbl_n%0d", tbl[i].n), rx_nib(tbl[i].n), mem[tbl[i].row*64 + tbl[i].col]);
        clear_rx();
        wait_bits(8, 400, ok);
        chk("c_bits_timeout", ok, 1);
        chk("c_sync_edges", sync_e, SC);
        chk("c_pix0", rx_nib(0), mem[0]);
        chk("c_pix1", rx_nib(1), mem[1]);
`endif
        chk("mosi_stable_high", unstable, 0);
        chk("mosi_idle_low", idle_mosi, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
